// File: rtl/audio_clk_nco.sv
// audio_clk_nco: fractional-N master clock (phase accumulator) with integer
// BCLK/LRCLK dividers and single-cycle strobes for an I2S serialiser.
// The frequency word is reprogrammed through an inc_load/inc_ack handshake.
// Optional build macro AUDIO_CLK_FRAME_ALIGN_EN: while running, hold a new
// frequency word until the next frame_tick so a stereo frame is never split.
module audio_clk_nco #(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(1055531163),
  parameter int               BCLK_DIV    = 4,
  parameter int               LR_BITS     = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             inc_ack,
  output logic             mclk_out,
  output logic             bclk_out,
  output logic             lrclk_out,
  output logic             bclk_fall_tick,
  output logic             frame_tick,
  output logic             running
);

  localparam int HALF_DIV = BCLK_DIV / 2;
  // Counters keep at least one bit so the degenerate ratios still elaborate.
  localparam int BC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int LC_W = (LR_BITS > 1) ? $clog2(LR_BITS) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(HALF_DIV - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LR_BITS - 1);

`ifdef AUDIO_CLK_FRAME_ALIGN_EN
  localparam logic FRAME_ALIGN = 1'b1;
`else
  localparam logic FRAME_ALIGN = 1'b0;
`endif

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             mclk_rise_reg;
  logic [BC_W-1:0]  bc_reg;
  logic [LC_W-1:0]  lc_reg;
  logic             bclk_reg;
  logic             lrclk_reg;
  logic             bclk_fall_tick_reg;
  logic             frame_tick_reg;
  logic             running_reg;
  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W-1:0] pend_inc_reg;
  logic             pend_reg;
  logic             inc_ack_reg;

  logic rise_next;
  logic bclk_toggle;
  logic bclk_fall;
  logic lr_toggle;
  logic frame_next;
  logic apply_pend;
  logic load_direct;

  // Next-phase, divider events and update decisions for the coming edge.
  always_comb begin
    acc_next    = acc_reg + inc_reg;
    rise_next   = ~acc_reg[ACC_W-1] & acc_next[ACC_W-1];
    bclk_toggle = enable & running_reg & mclk_rise_reg & (bc_reg == BC_LAST);
    bclk_fall   = bclk_toggle & bclk_reg;
    lr_toggle   = bclk_fall & (lc_reg == LC_LAST);
    frame_next  = lr_toggle & lrclk_reg;
    // A held word goes out when idle, immediately in free mode, or on a frame edge.
    apply_pend  = pend_reg & (~running_reg | ~FRAME_ALIGN | frame_next);
    // With nothing held, a load that needs no alignment bypasses the holding register.
    load_direct = inc_load & ~pend_reg & (~running_reg | ~FRAME_ALIGN);
  end

  // Phase accumulator and BCLK/LRCLK dividers; disable clears everything here.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc_reg            <= '0;
      mclk_rise_reg      <= 1'b0;
      bc_reg             <= '0;
      lc_reg             <= '0;
      bclk_reg           <= 1'b0;
      lrclk_reg          <= 1'b0;
      bclk_fall_tick_reg <= 1'b0;
      frame_tick_reg     <= 1'b0;
      running_reg        <= 1'b0;
    end else if (!enable) begin
      acc_reg            <= '0;
      mclk_rise_reg      <= 1'b0;
      bc_reg             <= '0;
      lc_reg             <= '0;
      bclk_reg           <= 1'b0;
      lrclk_reg          <= 1'b0;
      bclk_fall_tick_reg <= 1'b0;
      frame_tick_reg     <= 1'b0;
      running_reg        <= 1'b0;
    end else begin
      running_reg <= 1'b1;
      if (running_reg) begin
        acc_reg       <= acc_next;
        mclk_rise_reg <= rise_next;
      end else begin
        mclk_rise_reg <= 1'b0;
      end
      if (mclk_rise_reg) begin
        bc_reg <= (bc_reg == BC_LAST) ? '0 : bc_reg + 1'b1;
      end
      if (bclk_toggle) begin
        bclk_reg <= ~bclk_reg;
      end
      if (bclk_fall) begin
        lc_reg <= (lc_reg == LC_LAST) ? '0 : lc_reg + 1'b1;
      end
      if (lr_toggle) begin
        lrclk_reg <= ~lrclk_reg;
      end
      bclk_fall_tick_reg <= bclk_fall;
      frame_tick_reg     <= frame_next;
    end
  end

  // Frequency-word handshake; the phase is never touched by an update.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      inc_reg      <= INC_DEFAULT;
      pend_inc_reg <= '0;
      pend_reg     <= 1'b0;
      inc_ack_reg  <= 1'b0;
    end else begin
      inc_ack_reg <= apply_pend | load_direct;
      if (apply_pend) begin
        inc_reg <= pend_inc_reg;
      end else if (load_direct) begin
        inc_reg <= inc_in;
      end
      if (inc_load && !load_direct) begin
        pend_inc_reg <= inc_in;
        pend_reg     <= 1'b1;
      end else if (apply_pend) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign mclk_out       = acc_reg[ACC_W-1];
  assign bclk_out       = bclk_reg;
  assign lrclk_out      = lrclk_reg;
  assign bclk_fall_tick = bclk_fall_tick_reg;
  assign frame_tick     = frame_tick_reg;
  assign running        = running_reg;
  assign inc_ack        = inc_ack_reg;

endmodule

// File: tb/tb_audio_clk_nco.sv
// Scoreboard bench for audio_clk_nco: stimulus pushes expected event cycles
// into queues, a negedge monitor pops and compares as the DUT produces them.
// A small-parameter instance checks ratios, updates, enable and reset; a
// default instance checks the 50 MHz -> 12.288 MHz fractional ratio.
module tb_audio_clk_nco;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       en_s   = 1'b0;
  logic       en_d   = 1'b0;
  logic [7:0] inc_in = 8'd0;
  logic       inc_load = 1'b0;
  logic [31:0] d_inc_in = 32'd0;
  logic        d_load   = 1'b0;

  logic s_ack, s_mclk, s_bclk, s_lrclk, s_bft, s_ft, s_run;
  logic d_ack, d_mclk, d_bclk, d_lrclk, d_bft, d_ft, d_run;

  audio_clk_nco #(.ACC_W(8), .INC_DEFAULT(8'd64), .BCLK_DIV(4), .LR_BITS(2)) u_small (
    .clk_in(clk_in), .reset(reset), .enable(en_s), .inc_in(inc_in), .inc_load(inc_load),
    .inc_ack(s_ack), .mclk_out(s_mclk), .bclk_out(s_bclk), .lrclk_out(s_lrclk),
    .bclk_fall_tick(s_bft), .frame_tick(s_ft), .running(s_run)
  );

  audio_clk_nco u_dflt (
    .clk_in(clk_in), .reset(reset), .enable(en_d), .inc_in(d_inc_in), .inc_load(d_load),
    .inc_ack(d_ack), .mclk_out(d_mclk), .bclk_out(d_bclk), .lrclk_out(d_lrclk),
    .bclk_fall_tick(d_bft), .frame_tick(d_ft), .running(d_run)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int rise_q[$];
  int bfall_q[$];
  int frame_q[$];
  int ack_q[$];

  // monitor state
  logic pm = 1'b0, pb = 1'b0, dp = 1'b0;
  int   hi_len = 0;
  logic d_meas = 1'b0;
  int   d_rises = 0, d_frames = 0, d_last = -1, d_min = 1000, d_max = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  // Monitor: compares DUT events against the queued expectations.
  initial begin
    forever begin
      @(negedge clk_in);
      if (s_mclk && !pm && rise_q.size() > 0) chk("mclk_rise_cycle", cyc, rise_q.pop_front());
      if (s_mclk) hi_len++;
      else begin
        if (pm && s_run) chk_rng("mclk_high_len", hi_len, 2, 64);
        hi_len = 0;
      end
      if (s_bft) begin
        chk("bclk_fell", int'({pb, s_bclk}), 2);
        if (bfall_q.size() > 0) chk("bclk_fall_cycle", cyc, bfall_q.pop_front());
      end
      if (s_ft) begin
        chk("frame_with_bfall", int'(s_bft), 1);
        if (frame_q.size() > 0) chk("frame_tick_cycle", cyc, frame_q.pop_front());
      end
      if (s_ack) begin
        if (ack_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ack_unexpected: inc_ack high at cycle %0d, required no ack", cyc);
        end else begin
          chk("inc_ack_cycle", cyc, ack_q.pop_front());
        end
`ifdef AUDIO_CLK_FRAME_ALIGN_EN
        if (s_run) chk("ack_on_frame_tick", int'(s_ft), 1);
`endif
      end
      pm = s_mclk;
      pb = s_bclk;
      if (d_meas) begin
        if (d_mclk && !dp) d_rises++;
        if (d_ft) d_frames++;
        if (d_mclk != dp) begin
          if (d_last >= 0) begin
            if (cyc - d_last < d_min) d_min = cyc - d_last;
            if (cyc - d_last > d_max) d_max = cyc - d_last;
          end
          d_last = cyc;
        end
      end
      dp = d_mclk;
    end
  end

  task automatic chk_drained(input string tag);
    chk({tag, "_rise_q_empty"}, rise_q.size(), 0);
    chk({tag, "_ack_q_empty"}, ack_q.size(), 0);
    chk({tag, "_frame_q_empty"}, frame_q.size() + bfall_q.size(), 0);
  endtask

  int c0, c1, c2, c3, c4;

  // Stimulus: directed phases with hand-computed event cycles.
  initial begin
    step(3);
    chk("reset_clocks", int'({s_mclk, s_bclk, s_lrclk}), 0);
    chk("reset_ticks_ack", int'({s_bft, s_ft, s_ack}), 0);
    chk("reset_running", int'(s_run), 0);

    // Fractional ratio: 1 ms of the default instance.
    reset  = 1'b0;
    en_d   = 1'b1;
    d_meas = 1'b1;
    step(50000);
    d_meas = 1'b0;
    en_d   = 1'b0;
    chk_rng("mclk_rises_1ms", d_rises, 12287, 12289);
    chk_rng("frames_1ms", d_frames, 47, 49);
    chk_rng("mclk_min_phase", d_min, 2, 3);
    chk_rng("mclk_max_phase", d_max, 2, 3);

    // Basic ratios: rise 2 cycles after running, periods 4/16/64.
    c0 = cyc;
    for (int k = 0; k < 32; k++) rise_q.push_back(c0 + 3 + 4 * k);
    for (int j = 0; j < 8; j++) bfall_q.push_back(c0 + 16 + 16 * j);
    frame_q.push_back(c0 + 64);
    frame_q.push_back(c0 + 128);
    en_s = 1'b1;
    step(1);
    chk("running_latency", int'(s_run), 1);
    step(129);
    chk_drained("basic");

    // Frequency update to 32 mid-frame.
    c1 = cyc;
`ifdef AUDIO_CLK_FRAME_ALIGN_EN
    ack_q.push_back(c0 + 192);
    frame_q.push_back(c0 + 192);
    for (int k = 0; k < 16; k++) rise_q.push_back(c0 + 131 + 4 * k);
    for (int k = 0; k < 8; k++) rise_q.push_back(c0 + 198 + 8 * k);
    inc_in = 8'd100; inc_load = 1'b1; step(1); inc_load = 1'b0;
    step(4);
    inc_in = 8'd32;  inc_load = 1'b1; step(1); inc_load = 1'b0;
    step(c0 + 258 - cyc);
`else
    ack_q.push_back(c1 + 1);
    for (int k = 0; k < 8; k++) rise_q.push_back(c1 + 1 + 8 * k);
    inc_in = 8'd32; inc_load = 1'b1; step(1); inc_load = 1'b0;
    step(59);
`endif
    chk_drained("update");

    // Enable toggling: clear next cycle, idle load acked in one cycle.
    c2 = cyc;
    en_s = 1'b0;
    step(1);
    chk("disable_clocks", int'({s_mclk, s_bclk, s_lrclk}), 0);
    chk("disable_ticks_running", int'({s_bft, s_ft, s_run}), 0);
    step(1);
    ack_q.push_back(c2 + 3);
    inc_in = 8'd64; inc_load = 1'b1; step(1); inc_load = 1'b0;
    step(1);
    for (int k = 0; k < 8; k++) rise_q.push_back(c2 + 7 + 4 * k);
    en_s = 1'b1;
    step(40);
    chk_drained("reenable");

    // Asynchronous reset mid-frame; held/loaded word must be discarded.
    c3 = cyc;
`ifndef AUDIO_CLK_FRAME_ALIGN_EN
    ack_q.push_back(c3 + 1);
`endif
    inc_in = 8'd32; inc_load = 1'b1; step(1); inc_load = 1'b0;
    step(2);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_clocks", int'({s_mclk, s_bclk, s_lrclk}), 0);
    chk("async_reset_running", int'({s_bft, s_ft, s_run, s_ack}), 0);
    step(2);
    c4 = cyc;
    for (int k = 0; k < 8; k++) rise_q.push_back(c4 + 3 + 4 * k);
    frame_q.push_back(c4 + 64);
    reset = 1'b0;
    step(70);
    chk_drained("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_clk_nco.md
# audio_clk_nco

Parametrised audio clock generator for the WM8731 codec path. A phase accumulator (NCO) clocked by `clk_in` produces `mclk_out` at a fractional ratio of the input clock, so a 12.288 MHz master clock is derived correctly from 50 MHz. `bclk_out` and `lrclk_out` are divided from it with exact integer ratios, and the block emits single-cycle strobes for the downstream I2S serialiser. The frequency word can be reprogrammed at runtime through a load/acknowledge handshake.

## Interface
- `ACC_W`, 32: phase accumulator width; must be ≥ 8.
- `INC_DEFAULT`, 1055531163: increment after reset, equal to round(12.288/50 · 2^32).
- `BCLK_DIV`, 4: MCLK cycles per BCLK period; even, ≥ 2.
- `LR_BITS`, 32: BCLK periods per LRCLK half-period (per channel slot); ≥ 1.

Ports (clock and reset first):
- `clk_in`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high.
- `enable`, in, 1: run the generator; low stops and clears it.
- `inc_in`, in, `ACC_W`: new frequency word.
- `inc_load`, in, 1: one-cycle request to capture `inc_in`.
- `inc_ack`, out, 1: one-cycle pulse when the new word takes effect.
- `mclk_out`, out, 1: codec master clock.
- `bclk_out`, out, 1: I2S bit clock.
- `lrclk_out`, out, 1: I2S word select; 0 = left, 1 = right.
- `bclk_fall_tick`, out, 1: high in the cycle where `bclk_out` falls.
- `frame_tick`, out, 1: high in the cycle where `lrclk_out` falls (start of frame).
- `running`, out, 1: registered copy of `enable`.

## Operation
- **Reset.** All outputs are 0. The accumulator and all counters are 0. `inc_reg` = `INC_DEFAULT`. The pending flag is cleared.
- **Accumulator.** While `running` is high, `acc <= acc + inc_reg` every cycle, modulo 2^ACC_W.
  - `mclk_out` = `acc[ACC_W-1]`, taken directly from the register.
  - Frequency: f_mclk = inc_reg / 2^ACC_W · f_clk.
  - Edge jitter is ≤ 1 `clk_in` period.
- **MCLK rise detection.** An MCLK rise is the condition where the next-state MSB is 1 and the current MSB is 0. It is registered internally as `mclk_rise`.
- **BCLK.** A counter `bc` of width clog2(BCLK_DIV/2) counts `mclk_rise` events. When `bc == BCLK_DIV/2 - 1` on a rise, `bclk_out` toggles and `bc` returns to 0.
- **LRCLK.** A counter `lc` of width clog2(LR_BITS) counts BCLK falling edges.
  - When `lc == LR_BITS - 1` on a falling edge, `lrclk_out` toggles and `lc` returns to 0.
  - `lrclk_out` therefore changes only on BCLK falling edges, as I2S requires.
- **Disable.** When `enable` is low, on the next cycle:
  - `acc`, `bc`, `lc` are cleared.
  - `mclk_out`, `bclk_out`, `lrclk_out` and both ticks are 0.
  - `running` is 0.
  - `inc_reg` and the pending word are retained.
- **Enable.** The first `mclk_out` rise occurs in the first cycle where the accumulated phase reaches or exceeds 2^(ACC_W-1).
- **Frequency update.**
  - `inc_load` captures `inc_in` into `pend_inc` and sets `pend`.
  - The pending word is applied at the update point (see Configuration): `inc_reg <= pend_inc`, `pend` is cleared, and `inc_ack` pulses high for 1 cycle.
  - If the block is not running, the word is applied on the next cycle regardless of mode.
  - A load while `pend` is already set overwrites `pend_inc`. Only one ack is produced.
  - A load coinciding with the apply cycle: the old pending word is applied and acked, the new word is captured, and `pend` stays set.
  - The accumulator phase is never reset by an update, so `mclk_out` stays glitch-free: no runt pulse shorter than 1 `clk_in` period.
- **Reset mid-operation.** Reset takes effect immediately and asynchronously and returns the block to the reset state. Any pending word is lost.

## Timing
- `bclk_out` toggles 1 cycle after the cycle in which `mclk_out` rises (registered from `mclk_rise`).
- `bclk_fall_tick` and the `lrclk_out` toggle occur in the same cycle that `bclk_out` goes 1→0.
- `frame_tick` is high in the cycle where `lrclk_out` goes 1→0.
- Latency from `enable` to `running` is 1 cycle.
- With default parameters at 50 MHz:
  - MCLK averages 12.288 MHz.
  - BCLK = 3.072 MHz.
  - LRCLK = 48.000 kHz, with a mean error equal to the NCO rounding (< 0.01 ppm).

## Configuration
- `AUDIO_CLK_FRAME_ALIGN_EN` defined: while running, a pending word is applied only in a `frame_tick` cycle, so a frequency change never splits a stereo frame. `inc_ack` coincides with `frame_tick`.
- Not defined: a pending word is applied the cycle after `inc_load`, and `inc_ack` follows `inc_load` by 1 cycle.

## Test plan
- **Basic ratios.** `ACC_W`=8, `INC_DEFAULT`=64, `BCLK_DIV`=4, `LR_BITS`=2, `enable` high after reset. Required response:
  - `mclk_out` period = 4 cycles.
  - `bclk_out` period = 16 cycles.
  - `lrclk_out` period = 64 cycles.
  - One `frame_tick` every 64 cycles, coincident with `bclk_fall_tick`.
- **Fractional ratio.** Defaults, 1 ms of run time. Required response:
  - 12288 ± 1 `mclk_out` rises.
  - 48 ± 1 `frame_tick` pulses.
  - No MCLK high or low phase shorter than 2 or longer than 3 cycles.
- **Aligned update.** `AUDIO_CLK_FRAME_ALIGN_EN` defined, small parameters as in the first scenario, load `inc_in`=32 mid-frame. Required response:
  - `inc_ack` appears only in the next `frame_tick` cycle.
  - Afterwards the `mclk_out` period is 8 cycles.
  - Two loads within one frame produce a single ack, and the last value wins.
- **Unaligned update.** Macro undefined, load `inc_in`=32. Required response:
  - `inc_ack` follows 1 cycle after `inc_load`.
  - No `mclk_out` pulse is shorter than 2 cycles.
- **Enable toggling.** Drop `enable` mid-frame. Required response:
  - Next cycle, all clocks and ticks are 0 and `running` = 0.
  - After re-enable, the first `mclk_out` rise occurs 2 cycles later with INC=64, ACC_W=8.
  - The word loaded while disabled is acked in 1 cycle.
- **Asynchronous reset.** Assert `reset` mid-frame, between clock edges. Required response:
  - Outputs go to 0 without waiting for `clk_in`.
  - After release, `inc_reg` = `INC_DEFAULT`.
